// File: rtl/sobel_line_scheduler.sv
// ---------------------------------------------------------------------------
// sobel_line_scheduler
//
// Purpose:
//   Sequences the 3-line Sobel datapath between the camera FIFO and the Sobel
//   output FIFO. Words are pulled from the camera FIFO whenever it holds
//   enough data and the output FIFO has room. The block locks to frame start
//   using the SOF marker (bit 16 of the camera word). It tracks column, row and
//   ring-buffer position, and emits result strobes delayed to line up with
//   the datapath pipeline.
//
// Ports:
//   clk_w       in   sole clock
//   rst         in   synchronous, active-high reset
//   enable      in   run request, sampled in IDLE and at frame end
//   fifo_count  in   camera FIFO data count
//   fifo_sof    in   frame-start marker of the camera FIFO head word
//   out_afull   in   Sobel output FIFO almost-full
//   rd_en       out  camera FIFO read strobe (combinational)
//   pix_valid   out  head word is an accepted pixel (combinational)
//   wr_row_idx  out  ring buffer written by the current line
//   rd_top_idx  out  ring buffer holding line row-2
//   rd_mid_idx  out  ring buffer holding line row-1
//   wr_addr     out  current column (line-RAM write address)
//   rd_addr     out  current column (line-RAM read address, read-before-write)
//   out_valid   out  result strobe, PIPE_LAT cycles after the accept
//   out_border  out  result lies in the first two columns
//   out_eol     out  result is the last column of its line
//   out_eof     out  result is the last one of the frame
//   busy        out  controller is not idle
//   err_resync  out  one-cycle pulse after an unexpected frame-start marker
// ---------------------------------------------------------------------------
module sobel_line_scheduler #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 10,
  parameter int MIN_LEVEL  = 6,
  parameter int PIPE_LAT   = 2
) (
  input  logic                  clk_w,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  fifo_count,
  input  logic                  fifo_sof,
  input  logic                  out_afull,
  output logic                  rd_en,
  output logic                  pix_valid,
  output logic [1:0]            wr_row_idx,
  output logic [1:0]            rd_top_idx,
  output logic [1:0]            rd_mid_idx,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  out_valid,
  output logic                  out_border,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  busy,
  output logic                  err_resync
);

  localparam int ROW_WIDTH = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [ADDR_WIDTH-1:0] COL_LAST       = ADDR_WIDTH'(H_ACTIVE - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_BORDER_END = ADDR_WIDTH'(2);
  localparam logic [ROW_WIDTH-1:0]  ROW_LAST       = ROW_WIDTH'(V_ACTIVE - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_PRIME_LAST = ROW_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  LEVEL          = CNT_WIDTH'(MIN_LEVEL);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    PRIME    = 2'd2,
    STREAM   = 2'd3
  } state_t;

  state_t state;

  logic [ADDR_WIDTH-1:0] col;
  logic [ROW_WIDTH-1:0]  row;
  logic [1:0]            ring;

  // Result delay line, one entry per cycle: {valid, border, eol, eof}.
  logic [PIPE_LAT-1:0][3:0] pipe_q;

  logic                  go;
  logic                  in_frame;
  logic                  accept;
  logic                  resync;
  logic                  result;
  logic                  line_end;
  logic                  frame_end;
  logic [ADDR_WIDTH-1:0] cur_col;
  logic [ROW_WIDTH-1:0]  cur_row;
  logic [1:0]            cur_ring;
  logic [1:0]            next_ring;
  logic [3:0]            res_word;

  // Accept decision and the effective pixel position for this cycle. A
  // resync word is treated as pixel (0,0) of a fresh frame, so the position
  // seen by the line RAMs is overridden in the same cycle.
  always_comb begin
    in_frame  = (state == PRIME) || (state == STREAM);
    go        = (state != IDLE) && (fifo_count >= LEVEL) && !out_afull;
    accept    = go && (in_frame || fifo_sof);
    resync    = go && in_frame && fifo_sof && ((col != '0) || (row != '0));
    cur_col   = resync ? '0    : col;
    cur_row   = resync ? '0    : row;
    cur_ring  = resync ? 2'd0  : ring;
    next_ring = (cur_ring == 2'd2) ? 2'd0 : cur_ring + 2'd1;
    line_end  = (cur_col == COL_LAST);
    frame_end = line_end && (cur_row == ROW_LAST);
    result    = accept && (state == STREAM) && !resync;
    res_word  = {result,
                 result && (cur_col < COL_BORDER_END),
                 result && line_end,
                 result && frame_end};
  end

  // Ring read indices trail the write index by one and two lines (mod 3).
  always_comb begin
    rd_mid_idx = 2'd1;
    rd_top_idx = 2'd0;
    case (cur_ring)
      2'd0: begin
        rd_mid_idx = 2'd2;
        rd_top_idx = 2'd1;
      end
      2'd1: begin
        rd_mid_idx = 2'd0;
        rd_top_idx = 2'd2;
      end
      default: begin
        rd_mid_idx = 2'd1;
        rd_top_idx = 2'd0;
      end
    endcase
  end

  // Control FSM, position counters, resync flag and the result delay line.
  // The delay line shifts every cycle regardless of stalls so that output
  // gaps mirror input gaps.
  always_ff @(posedge clk_w) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      ring       <= 2'd0;
      err_resync <= 1'b0;
      pipe_q     <= '0;
    end else begin
      err_resync <= resync;
      pipe_q[0]  <= res_word;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state <= WAIT_SOF;
          end
        end

        default: begin
          if (accept) begin
            if (!line_end) begin
              col  <= cur_col + 1'b1;
              row  <= cur_row;
              ring <= cur_ring;
              // Leaving WAIT_SOF or resyncing always lands in PRIME.
              state <= (state == STREAM && !resync) ? STREAM : PRIME;
            end else if ((state == STREAM) && !resync && frame_end) begin
              col   <= '0;
              row   <= '0;
              ring  <= 2'd0;
              state <= enable ? WAIT_SOF : IDLE;
            end else begin
              col  <= '0;
              row  <= cur_row + 1'b1;
              ring <= next_ring;
              if ((state == STREAM) && !resync) begin
                state <= STREAM;
              end else if (cur_row == ROW_PRIME_LAST) begin
                state <= STREAM;
              end else begin
                state <= PRIME;
              end
            end
          end
        end
      endcase
    end
  end

  assign rd_en      = go;
  assign pix_valid  = accept;
  assign wr_row_idx = cur_ring;
  assign wr_addr    = cur_col;
  assign rd_addr    = cur_col;
  assign busy       = (state != IDLE);
  assign out_valid  = pipe_q[PIPE_LAT-1][3];
  assign out_border = pipe_q[PIPE_LAT-1][2];
  assign out_eol    = pipe_q[PIPE_LAT-1][1];
  assign out_eof    = pipe_q[PIPE_LAT-1][0];

endmodule

// File: tb/tb_sobel_line_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sobel_line_scheduler
//
// Purpose:
//   Self-checking bench for sobel_line_scheduler with an 8x4 frame. A
//   frame-level reference model (mode + linear pixel index) predicts every
//   output each cycle; directed scenarios add event-count checks on top.
// ---------------------------------------------------------------------------
module tb_sobel_line_scheduler;

  localparam int H      = 8;
  localparam int V      = 4;
  localparam int LAT    = 2;
  localparam int MINL   = 6;
  localparam int CW     = 10;
  localparam int AW     = 10;
  localparam int NPIX   = H * V;
  localparam int MAXCYC = 8192;

  logic          clk_w;
  logic          rst;
  logic          enable;
  logic [CW-1:0] fifo_count;
  logic          fifo_sof;
  logic          out_afull;
  logic          rd_en;
  logic          pix_valid;
  logic [1:0]    wr_row_idx;
  logic [1:0]    rd_top_idx;
  logic [1:0]    rd_mid_idx;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic          out_border;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          err_resync;

  sobel_line_scheduler #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW),
    .MIN_LEVEL (MINL),
    .PIPE_LAT  (LAT)
  ) dut (
    .clk_w     (clk_w),
    .rst       (rst),
    .enable    (enable),
    .fifo_count(fifo_count),
    .fifo_sof  (fifo_sof),
    .out_afull (out_afull),
    .rd_en     (rd_en),
    .pix_valid (pix_valid),
    .wr_row_idx(wr_row_idx),
    .rd_top_idx(rd_top_idx),
    .rd_mid_idx(rd_mid_idx),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .out_valid (out_valid),
    .out_border(out_border),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .err_resync(err_resync)
  );

  initial clk_w = 1'b0;
  always #5 clk_w = ~clk_w;

  // Reference model: idle, hunting for SOF, or locked with a linear pixel index.
  typedef enum int {M_IDLE, M_HUNT, M_LOCK} mode_t;
  mode_t      m_mode;
  int         m_idx;
  logic [3:0] m_res [MAXCYC];
  logic       m_err [MAXCYC];

  int cyc;
  int n_cmp;
  int n_fail;

  int cnt_pix, cnt_disc, cnt_stall, cnt_res, cnt_border, cnt_eol, cnt_eof, cnt_err;
  int first_res_cyc, pix17_cyc;
  int ring_q[$];

  logic       s_rd, s_pix, s_busy;
  logic [1:0] s_ring;
  logic [AW-1:0] s_addr;

  typedef struct {
    logic en;
    int   cnt;
    logic afull;
    logic sof;
    logic e_rd;
    logic e_pix;
    logic e_busy;
    int   e_addr;
    int   e_ring;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clearCounts();
    cnt_pix = 0; cnt_disc = 0; cnt_stall = 0; cnt_res = 0;
    cnt_border = 0; cnt_eol = 0; cnt_eof = 0; cnt_err = 0;
    first_res_cyc = -1; pix17_cyc = -1;
    ring_q.delete();
  endtask

  // Compares every DUT output against the model, then advances the model
  // across the coming clock edge.
  task automatic checkOutput();
    logic go, pix, rs;
    int   cidx, ring;
    go   = (m_mode != M_IDLE) && (int'(fifo_count) >= MINL) && !out_afull;
    pix  = 1'b0;
    rs   = 1'b0;
    cidx = m_idx;
    if (go && m_mode == M_HUNT && fifo_sof) begin
      pix  = 1'b1;
      cidx = 0;
    end
    if (go && m_mode == M_LOCK) begin
      pix = 1'b1;
      if (fifo_sof && m_idx != 0) begin
        rs   = 1'b1;
        cidx = 0;
      end
    end
    ring = (cidx / H) % 3;

    check("rd_en",      rd_en,      go);
    check("pix_valid",  pix_valid,  pix);
    check("wr_addr",    wr_addr,    cidx % H);
    check("rd_addr",    rd_addr,    cidx % H);
    check("wr_row_idx", wr_row_idx, ring);
    check("rd_mid_idx", rd_mid_idx, (ring + 2) % 3);
    check("rd_top_idx", rd_top_idx, (ring + 1) % 3);
    check("busy",       busy,       m_mode != M_IDLE);
    check("out_valid",  out_valid,  m_res[cyc][3]);
    check("out_border", out_border, m_res[cyc][2]);
    check("out_eol",    out_eol,    m_res[cyc][1]);
    check("out_eof",    out_eof,    m_res[cyc][0]);
    check("err_resync", err_resync, m_err[cyc]);

    if (rst) begin
      m_mode = M_IDLE;
      m_idx  = 0;
      for (int k = 1; k <= LAT; k++) begin
        m_res[cyc+k] = 4'b0;
        m_err[cyc+k] = 1'b0;
      end
    end else if (m_mode == M_IDLE) begin
      if (enable) m_mode = M_HUNT;
    end else if (pix) begin
      if (rs) m_err[cyc+1] = 1'b1;
      if (cidx >= 2 * H)
        m_res[cyc+LAT] = {1'b1, (cidx % H) < 2, (cidx % H) == H - 1, cidx == NPIX - 1};
      if (cidx == NPIX - 1) begin
        m_idx  = 0;
        m_mode = enable ? M_HUNT : M_IDLE;
      end else begin
        m_idx  = cidx + 1;
        m_mode = M_LOCK;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input int c,
                               input logic a, input logic s);
    if (cyc >= MAXCYC - LAT - 2) begin
      $display("[TB] FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXCYC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    rst        = r;
    enable     = e;
    fifo_count = CW'(c);
    out_afull  = a;
    fifo_sof   = s;
    @(negedge clk_w);
    checkOutput();
    s_rd   = rd_en;
    s_pix  = pix_valid;
    s_busy = busy;
    s_addr = wr_addr;
    s_ring = wr_row_idx;
    if (pix_valid === 1'b1) begin
      cnt_pix++;
      if (cnt_pix == 17) pix17_cyc = cyc;
      if (wr_addr == '0) ring_q.push_back(int'(wr_row_idx));
    end
    if (rd_en === 1'b1 && pix_valid === 1'b0) cnt_disc++;
    if (rd_en === 1'b0) cnt_stall++;
    if (out_valid === 1'b1) begin
      cnt_res++;
      if (first_res_cyc < 0) first_res_cyc = cyc;
      if (out_border === 1'b1) cnt_border++;
      if (out_eol === 1'b1) cnt_eol++;
      if (out_eof === 1'b1) cnt_eof++;
    end
    if (err_resync === 1'b1) cnt_err++;
    @(posedge clk_w);
    #1;
    cyc++;
  endtask

  initial begin
    vec_t tbl[9];
    int   exp_ring[4];
    int   exp_stall;
    int   k;

    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    m_mode = M_IDLE;
    m_idx = 0;
    for (int i = 0; i < MAXCYC; i++) begin
      m_res[i] = 4'b0;
      m_err[i] = 1'b0;
    end
    exp_ring = '{0, 1, 2, 0};

    //         en    cnt afull sof   rd    pix   busy  addr ring
    tbl[0] = '{1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1] = '{1'b1, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[2] = '{1'b1, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[3] = '{1'b1, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[4] = '{1'b1, 20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
    tbl[5] = '{1'b1, 20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0};
    tbl[6] = '{1'b1,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0};
    tbl[7] = '{1'b1, 20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0};
    tbl[8] = '{1'b1,  6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 0};

    rst = 1'b1; enable = 1'b0; fifo_count = '0; out_afull = 1'b0; fifo_sof = 1'b0;
    repeat (2) @(posedge clk_w);
    #1;

    // Scenario 1/2: garbage words, SOF, one full frame and its results.
    $display("[TB] basic frame");
    clearCounts();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, tbl[i].en, tbl[i].cnt, tbl[i].afull, tbl[i].sof);
      check("tbl_rd_en",   s_rd,   tbl[i].e_rd);
      check("tbl_pix",     s_pix,  tbl[i].e_pix);
      check("tbl_busy",    s_busy, tbl[i].e_busy);
      check("tbl_addr",    s_addr, tbl[i].e_addr);
      check("tbl_ring",    s_ring, tbl[i].e_ring);
    end
    k = 0;
    while (cnt_pix < NPIX && k < 100) begin
      applyStimulus(1'b0, 1'b1, 20, 1'b0, 1'b0);
      k++;
    end
    repeat (4) applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("s1_pix_count", cnt_pix, NPIX);
    check("s1_discards", cnt_disc, 3);
    check("s1_ring_len", ring_q.size(), 4);
    for (int i = 0; i < 4 && i < ring_q.size(); i++)
      check("s1_ring_seq", ring_q[i], exp_ring[i]);
    check("s1_results", cnt_res, (V - 2) * H);
    check("s1_latency", first_res_cyc - pix17_cyc, LAT);
    check("s1_border", cnt_border, (V - 2) * 2);
    check("s1_eol", cnt_eol, V - 2);
    check("s1_eof", cnt_eof, 1);
    check("s1_busy_wait_sof", busy, 1'b1);

    // Scenario 3: backpressure and low FIFO level stalls.
    $display("[TB] stalls");
    clearCounts();
    exp_stall = 0;
    k = 0;
    while (cnt_pix < NPIX && k < 300) begin
      if ((k % 7 == 5) || ((k / 3) % 2 == 1)) exp_stall++;
      applyStimulus(1'b0, 1'b1, (k % 7 == 5) ? 5 : 20, ((k / 3) % 2) == 1, cnt_pix == 0);
      k++;
    end
    check("s3_pix_count", cnt_pix, NPIX);
    check("s3_stalls", cnt_stall, exp_stall);
    repeat (4) applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("s3_results", cnt_res, (V - 2) * H);
    check("s3_eof", cnt_eof, 1);

    // Scenario 4: SOF injected at row 2 col 5.
    $display("[TB] resync");
    clearCounts();
    k = 0;
    while (cnt_pix < 2 * H + 5 + NPIX && k < 200) begin
      applyStimulus(1'b0, 1'b1, 20, 1'b0, (cnt_pix == 0) || (cnt_pix == 2 * H + 5));
      k++;
    end
    repeat (4) applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("s4_pix_count", cnt_pix, 2 * H + 5 + NPIX);
    check("s4_err", cnt_err, 1);
    check("s4_results", cnt_res, 5 + (V - 2) * H);
    check("s4_eof", cnt_eof, 1);

    // Scenario 5a: enable dropped during row 1.
    $display("[TB] enable drop");
    clearCounts();
    k = 0;
    while (cnt_pix < NPIX && k < 100) begin
      applyStimulus(1'b0, cnt_pix < H, 20, 1'b0, cnt_pix == 0);
      k++;
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 20, 1'b0, 1'b0);
    check("s5_pix_count", cnt_pix, NPIX);
    check("s5_results", cnt_res, (V - 2) * H);
    check("s5_busy", busy, 1'b0);
    check("s5_rd_en", rd_en, 1'b0);

    // Scenario 5b: reset at row 3 col 4.
    $display("[TB] mid-frame reset");
    clearCounts();
    applyStimulus(1'b0, 1'b1, 20, 1'b0, 1'b0);
    k = 0;
    while (cnt_pix < 3 * H + 4 && k < 100) begin
      applyStimulus(1'b0, 1'b1, 20, 1'b0, cnt_pix == 0);
      k++;
    end
    check("s5_pre_reset_pix", cnt_pix, 3 * H + 4);
    applyStimulus(1'b1, 1'b0, 20, 1'b0, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_border", out_border, 1'b0);
    check("rst_out_eol", out_eol, 1'b0);
    check("rst_out_eof", out_eof, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_err", err_resync, 1'b0);
    cnt_res = 0;
    repeat (6) applyStimulus(1'b0, 1'b0, 20, 1'b0, 1'b0);
    check("rst_no_late_results", cnt_res, 0);

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 19) != 0,
                    int'($urandom_range(0, 20)), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_line_scheduler.md
# sobel_line_scheduler

Single-clock controller that sequences the 3-line Sobel datapath between the camera FIFO and the Sobel output FIFO. It consumes pixels when the camera FIFO holds enough words and the output FIFO has room, and locks to frame start using the marker bit carried in bit 16 of the camera word. It drives ring-buffer row selection and line-RAM addresses, and produces output-valid, border, end-of-line and end-of-frame strobes aligned to the datapath pipeline.

## Interface
Parameters:
- H_ACTIVE, 640: pixels per line.
- V_ACTIVE, 480: lines per frame.
- ADDR_WIDTH, 10: line-RAM address width; must satisfy 2^ADDR_WIDTH ≥ H_ACTIVE.
- CNT_WIDTH, 10: camera FIFO data-count width.
- MIN_LEVEL, 6: minimum camera FIFO count required to read.
- PIPE_LAT, 2: cycles from pixel accept to datapath result (≥1).

Ports:
- clk_w  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled only in IDLE and at frame end.
- fifo_count  in  CNT_WIDTH  camera FIFO data count.
- fifo_sof  in  1  bit 16 of the camera FIFO head word (first-word-fall-through).
- out_afull  in  1  Sobel output FIFO almost-full.
- rd_en  out  1  camera FIFO read strobe.
- pix_valid  out  1  head word is an accepted pixel; datapath shifts and writes its line RAM.
- wr_row_idx  out  2  ring buffer (0..2) written by the current line.
- rd_top_idx, rd_mid_idx  out  2 each  ring buffers holding lines row-2 and row-1.
- wr_addr, rd_addr  out  ADDR_WIDTH each  current column (rd_addr = wr_addr; RAM is read-before-write).
- out_valid, out_border, out_eol, out_eof  out  1 each  pipeline-aligned result strobes.
- busy  out  1  state ≠ IDLE.
- err_resync  out  1  one-cycle pulse on an unexpected frame-start marker.

## Operation
- States: IDLE, WAIT_SOF, PRIME, STREAM.
- Read condition: go = (state ∈ {WAIT_SOF, PRIME, STREAM}) & (fifo_count ≥ MIN_LEVEL) & !out_afull.
- rd_en = go, combinational. One word is consumed per cycle with rd_en=1.
- IDLE: when enable=1, move to WAIT_SOF.
- WAIT_SOF, rd_en=1, fifo_sof=0: word discarded; pix_valid=0.
- WAIT_SOF, rd_en=1, fifo_sof=1: word is pixel (row 0, col 0); pix_valid=1; move to PRIME.
- Counters: col runs 0..H_ACTIVE-1 and advances on every accepted pixel. On wrap, row increments and wr_row_idx advances 0→1→2→0.
- Ring indices: rd_mid_idx = wr_row_idx-1 mod 3; rd_top_idx = wr_row_idx-2 mod 3.
- PRIME covers rows 0 and 1; no results are produced. After the last pixel of row 1, move to STREAM.
- STREAM covers rows 2..V_ACTIVE-1. Every accepted pixel generates one result.
  - out_border=1 when col<2 (the window spans the line wrap; datapath forces zero).
  - out_eol=1 at col=H_ACTIVE-1.
  - out_eof=1 at the last pixel of the frame.
- Frame end: after the last pixel of row V_ACTIVE-1, go to WAIT_SOF if enable=1, else IDLE. Counters and wr_row_idx return to 0.
- Resync: in PRIME/STREAM, an accepted word with fifo_sof=1 at any position other than (0,0):
  - err_resync pulses.
  - The word becomes pixel (0,0); counters and ring index reset.
  - State becomes PRIME.
  - Results already in the pipeline still emerge.
- Deasserting enable mid-frame has no effect until frame end.
- Results per frame: (V_ACTIVE-2)·H_ACTIVE.

## Timing
- Reset values: state IDLE; col, row and wr_row_idx 0; all outputs 0. rd_top_idx=1 and rd_mid_idx=2, following the ring formula.
- rd_en, pix_valid, wr_addr and the ring indices are combinational from registers and inputs, valid in the accept cycle.
- Counters and state update on the clk_w edge that ends an accept cycle.
- out_valid/out_border/out_eol/out_eof are registered and follow the generating accept by exactly PIPE_LAT cycles. Stalls do not hold the pipeline delay line, so output gaps mirror input gaps.
- rst asserted mid-frame clears the state and the delay line on the next edge; no stale out_valid appears afterwards.
- fifo_count = MIN_LEVEL-1, or out_afull=1: rd_en=0 in that same cycle.
- Maximum throughput: one pixel per cycle.

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=4, PIPE_LAT=2, with the FIFO held at count 20.
- Reset, then enable=1, 3 garbage words, then SOF and 32 pixels → 3 discards with pix_valid=0; pix_valid asserted 32 times; wr_row_idx sequence 0,1,2,0 per line.
- Same frame, check result strobes → out_valid count = 16, first out_valid 2 cycles after accept of (2,0); out_border on cols 0–1; out_eol every 8th result; a single out_eof; state back to WAIT_SOF.
- Toggle out_afull every 3 cycles, and separately hold fifo_count=5 → rd_en=0 on exactly those cycles; total result count is still 16 with no duplicates.
- SOF injected at (2,5) → err_resync pulses once; that word is (0,0); PRIME restarts; the next frame completes with 16 results.
- enable=0 at row 1 → frame completes, then IDLE with busy=0; rst asserted at row 3 col 4 → all outputs 0 next cycle and no later out_valid.
